// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel-tick divider, hc/vc scan counters and a one-tick
// registered pin stage that blanks the returned colour outside the active window.
module vga_scan_timing #(
  parameter int DIV     = 2,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 144,
  parameter int H_FP    = 784,
  parameter int V_TOTAL = 521,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 31,
  parameter int V_FP    = 511
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rgb_in,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        pix_en,
  output logic        video_on,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [10:0]     H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]     V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]     H_SYNC_C = 11'(H_SYNC);
  localparam logic [10:0]     H_BP_C   = 11'(H_BP);
  localparam logic [10:0]     H_FP_C   = 11'(H_FP);
  localparam logic [10:0]     V_SYNC_C = 11'(V_SYNC);
  localparam logic [10:0]     V_BP_C   = 11'(V_BP);
  localparam logic [10:0]     V_FP_C   = 11'(V_FP);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [10:0]   hc_q, hc_d;
  logic [10:0]   vc_q, vc_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;

  // tick is the single strobe: counters and the pin registers all advance on
  // the same edge, and rgb_in carries no handshake -- it must be settled by then.
  always_comb begin
    tick   = (div_cnt_q == DIV_LAST);
    h_wrap = (hc_q == H_LAST);
    v_wrap = (vc_q == V_LAST);
    active = (hc_q >= H_BP_C) && (hc_q < H_FP_C) &&
             (vc_q >= V_BP_C) && (vc_q < V_FP_C);
  end

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    hc_d      = hc_q;
    vc_d      = vc_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    if (tick) begin
      hc_d = h_wrap ? 11'd0 : hc_q + 11'd1;
      if (h_wrap) begin
        vc_d = v_wrap ? 11'd0 : vc_q + 11'd1;
      end
      // Pins describe the pixel the counters held during this tick.
      hsync_d = ~(hc_q < H_SYNC_C);
      vsync_d = ~(vc_q < V_SYNC_C);
      rgb_d   = active ? rgb_in : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 8'h00;
    end else begin
      div_cnt_q <= div_cnt_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  always_comb begin
    hc          = hc_q;
    vc          = vc_q;
    pix_en      = tick;
    video_on    = active;
    frame_start = tick && h_wrap && v_wrap;
    hsync       = hsync_q;
    vsync       = vsync_q;
    red         = rgb_q[7:5];
    green       = rgb_q[4:2];
    blue        = rgb_q[1:0];
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing on a shrunken raster so whole frames fit in a short run.
module tb_vga_scan_timing;

  localparam int DIV = 2;
  localparam int HT  = 16;
  localparam int HS  = 3;
  localparam int HB  = 5;
  localparam int HF  = 13;
  localparam int VT  = 9;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VF  = 7;
  localparam int FRAME      = HT * VT;
  localparam int FRAME_CLKS = FRAME * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rgb_in = 8'h00;
  logic [10:0] hc, vc;
  logic        pix_en, video_on, frame_start, hsync, vsync;
  logic [2:0]  red, green;
  logic [1:0]  blue;

  vga_scan_timing #(
    .DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_FP(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .hc(hc), .vc(vc), .pix_en(pix_en), .video_on(video_on),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int k = 0;

  // edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rgb_fn(input int m, input int h, input int v);
    case (m)
      0:       return 8'hFF;
      1:       return 8'b101_010_11;
      default: return 8'(((h & 15) << 4) | (v & 15)) ^ 8'h5A;
    endcase
  endfunction

  function automatic bit in_active(input int h, input int v);
    return (h >= HB) && (h < HF) && (v >= VB) && (v < VF);
  endfunction

  // model: position follows from edge count; pins show the previous tick's pixel
  logic [7:0] drv_at [FRAME];
  int  m_hc, m_vc;
  bit  m_pix, m_vid, m_fs, e_hs, e_vs;
  logic [7:0] e_rgb;

  initial begin
    int ticks, p, q;
    forever begin
      @(negedge clk);
      p = 0;
      if (!rst_n) begin
        m_hc = 0; m_vc = 0; m_pix = 0; m_vid = 0; m_fs = 0;
        e_hs = 1; e_vs = 1; e_rgb = 8'h00;
      end else begin
        ticks = k / DIV;
        p     = ticks % FRAME;
        m_hc  = p % HT;
        m_vc  = p / HT;
        m_pix = (k % DIV) == DIV - 1;
        m_vid = in_active(m_hc, m_vc);
        m_fs  = m_pix && (p == FRAME - 1);
        if (ticks == 0) begin
          e_hs = 1; e_vs = 1; e_rgb = 8'h00;
        end else begin
          q     = (ticks - 1) % FRAME;
          e_hs  = (q % HT) >= HS;
          e_vs  = (q / HT) >= VS;
          e_rgb = in_active(q % HT, q / HT) ? drv_at[q] : 8'h00;
        end
      end
      check("hc", 32'(hc), 32'(m_hc));
      check("vc", 32'(vc), 32'(m_vc));
      check("pix_en", 32'(pix_en), 32'(m_pix));
      check("video_on", 32'(video_on), 32'(m_vid));
      check("frame_start", 32'(frame_start), 32'(m_fs));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("rgb", 32'({red, green, blue}), 32'(e_rgb));
      rgb_in    = rgb_fn(mode, m_hc, m_vc);
      drv_at[p] = rgb_in;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int h, input int v);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step();
      if (m_pix && m_hc == h && m_vc == v) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL run_to: position (%0d,%0d) not reached, required within %0d clks", h, v, 2 * FRAME_CLKS);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_hc"}, 32'(hc), 0);
    check({tag, "_vc"}, 32'(vc), 0);
    check({tag, "_pix_en"}, 32'(pix_en), 0);
    check({tag, "_video_on"}, 32'(video_on), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_hsync"}, 32'(hsync), 1);
    check({tag, "_vsync"}, 32'(vsync), 1);
    check({tag, "_rgb"}, 32'({red, green, blue}), 0);
  endtask

  initial begin
    int hc_tab [5];
    int pe_tab [5];
    int nz, hl, vl, fs, pe;
    hc_tab = '{0, 1, 1, 2, 2};
    pe_tab = '{1, 0, 1, 0, 1};

    // reset and divider
    repeat (5) step();
    check_reset_pins("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("div_hc", 32'(hc), 32'(hc_tab[i]));
      check("div_pix_en", 32'(pix_en), 32'(pe_tab[i]));
    end

    // one full frame of counts with constant white input
    nz = 0; hl = 0; vl = 0; fs = 0; pe = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if ({red, green, blue} != 8'h00) nz++;
      if (!hsync) hl++;
      if (!vsync) vl++;
      if (frame_start) fs++;
      if (pix_en) pe++;
    end
    check("frame_lit_clks", 32'(nz), 64);
    check("frame_hsync_low_clks", 32'(hl), 54);
    check("frame_vsync_low_clks", 32'(vl), 64);
    check("frame_start_pulses", 32'(fs), 1);
    check("frame_ticks", 32'(pe), 144);

    // line wrap and hsync width
    run_to(15, 1);
    check("lw_hc", 32'(hc), 15);
    step();
    check("lw_hc_wrap", 32'(hc), 0);
    check("lw_vc_inc", 32'(vc), 2);
    check("lw_hsync_prev", 32'(hsync), 1);
    run_to(2, 2);  check("hs_from_1", 32'(hsync), 0);
    run_to(3, 2);  check("hs_from_2", 32'(hsync), 0);
    run_to(4, 2);  check("hs_from_3", 32'(hsync), 1);

    // frame wrap and vsync width
    run_to(15, 8);
    check("fw_frame_start", 32'(frame_start), 1);
    step();
    check("fw_frame_start_drop", 32'(frame_start), 0);
    check("fw_hc", 32'(hc), 0);
    check("fw_vc", 32'(vc), 0);
    check("fw_vsync_prev", 32'(vsync), 1);
    run_to(1, 0);  check("vs_from_0_0", 32'(vsync), 0);
    run_to(0, 2);  check("vs_from_15_1", 32'(vsync), 0);
    run_to(1, 2);  check("vs_from_0_2", 32'(vsync), 1);

    // blanking edges
    run_to(5, 3);  check("blank_left", 32'({red, green, blue}), 32'h00);
    run_to(6, 3);  check("first_active", 32'({red, green, blue}), 32'hFF);
    run_to(13, 6); check("last_active", 32'({red, green, blue}), 32'hFF);
    run_to(14, 6); check("blank_right", 32'({red, green, blue}), 32'h00);
    run_to(6, 7);  check("blank_bottom", 32'({red, green, blue}), 32'h00);
    run_to(6, 2);  check("blank_top", 32'({red, green, blue}), 32'h00);

    // colour pass-through
    mode = 1;
    run_to(7, 4);
    check("spot_video_on", 32'(video_on), 1);
    step();
    check("spot_red", 32'(red), 32'h5);
    check("spot_green", 32'(green), 32'h2);
    check("spot_blue", 32'(blue), 32'h3);
    run_to(1, 4);  check("spot_blanked", 32'({red, green, blue}), 32'h00);

    // position-dependent colour, checked every cycle by the model
    mode = 2;
    repeat (2 * FRAME_CLKS) step();

    // mid-frame asynchronous reset
    run_to(8, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_pins("async");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("resume_hc0", 32'(hc), 0);
    check("resume_pix_en", 32'(pix_en), 1);
    step();
    check("resume_hc1", 32'(hc), 1);
    check("resume_vc0", 32'(vc), 0);
    repeat (FRAME_CLKS) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
